tinker_mem_arbiter: RTL and testbench

// - Shares the single Tinker memory port between instruction fetch (32-bit read) and data access (64-bit load/store).
// - Sits between tinker_core fetch/control logic and the memory; memory is byte-addressed, big-endian.
// - One transaction is outstanding at a time. Data side has priority, with a starvation guard for fetch.

---
 rtl/tinker_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_tinker_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: shares the single Tinker memory port between instruction
// fetch (32-bit reads) and data access (64-bit loads/stores). Data side wins
// arbitration unless fetch has been passed over STARVE_MAX times in a row.
// Latency: 1 arbitration cycle, then the transaction; rvalid is combinational
// with mem_ack, so a zero-wait memory costs 2 cycles per transaction.
// Backpressure: requesters hold req level-high until their rvalid pulse; one
// transaction outstanding, memory outputs held stable until mem_ack.
// Optional macro TINKER_ARB_TIMEOUT_EN: watchdog that ends a BUSY state after
// TIMEOUT_CYC cycles without mem_ack, pulsing arb_err (arb_err is 0 otherwise).
//
// Ports:
//   clk, reset                   clock (rising edge), async active-high reset
//   if_req/if_addr               fetch request (level) and byte address
//   if_gnt/if_rvalid/if_rdata    fetch owns port / data valid pulse / data
//   d_req/d_we/d_addr/d_wdata    data request (level), store flag, addr, data
//   d_gnt/d_rvalid/d_rdata       data owns port / done pulse / load data
//   mem_req/mem_we/mem_size      memory request, write enable, 0=4B 1=8B
//   mem_addr/mem_wdata           memory byte address and write data
//   mem_ack/mem_rdata            completion pulse and read data
//   arb_err                      watchdog timeout pulse
module tinker_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          timeout;
  logic          done;
  logic          d_wins;

`ifdef TINKER_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wdog;

  // A real ack in the limit cycle takes precedence over the timeout.
  assign timeout = (state != IDLE) && !mem_ack && (wdog == WW'(TIMEOUT_CYC));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  assign arb_err = timeout;
  assign done    = mem_ack | timeout;

  // Data wins unless fetch is also waiting and has been starved long enough.
  assign d_wins = d_req && (!if_req || (starve_cnt < STARVE_LIM));

  // Completion is combinational with mem_ack; an ack seen in IDLE is stale and
  // cannot reach either requester because rvalid is qualified by the state.
  assign if_rvalid = (state == BUSY_IF) && done;
  assign d_rvalid  = (state == BUSY_D)  && done;
  // Timeout completions return zero data (mem_ack is low in that cycle).
  assign if_rdata  = (if_rvalid && mem_ack) ? mem_rdata[31:0] : 32'd0;
  assign d_rdata   = (d_rvalid && mem_ack && !mem_we) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_size   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
`ifdef TINKER_ARB_TIMEOUT_EN
      wdog       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef TINKER_ARB_TIMEOUT_EN
          wdog <= '0;
`endif
          if (d_wins) begin
            state     <= BUSY_D;
            d_gnt     <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_size  <= 1'b1;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // d_wins with if_req implies starve_cnt < limit, so the
            // increment saturates at STARVE_MAX by construction.
            if (if_req) starve_cnt <= starve_cnt + 1'b1;
            else        starve_cnt <= '0;
          end else if (if_req) begin
            state      <= BUSY_IF;
            if_gnt     <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_size   <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (done) begin
            state   <= IDLE;
            if_gnt  <= 1'b0;
            d_gnt   <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
`ifdef TINKER_ARB_TIMEOUT_EN
            wdog    <= '0;
          end else begin
            wdog    <= wdog + 1'b1;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          if_gnt  <= 1'b0;
          d_gnt   <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Testbench for tinker_mem_arbiter: table-driven single transactions plus
// hand-written sequences for starvation order, mid-transaction reset,
// back-to-back requests and the watchdog (with or without its macro).
module tb_tinker_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;
  logic        mem_req, mem_we, mem_size;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        arb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tinker_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_MAX(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  typedef struct {
    string       name;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] mrdata;
    int          delay;      // cycles between first mem_req cycle and mem_ack
    logic        exp_we;
    logic        exp_size;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Returns at the negedge of the first cycle with mem_req high.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    wait_req(ok);
    chk({v.name, "/granted"}, 64'(ok), 64'd1);
    if (!ok) begin
      if_req = 1'b0; d_req = 1'b0;
      return;
    end
    chk({v.name, "/addr"},  64'(mem_addr), 64'(v.addr));
    chk({v.name, "/we"},    64'(mem_we),   64'(v.exp_we));
    chk({v.name, "/size"},  64'(mem_size), 64'(v.exp_size));
    chk({v.name, "/wdata"}, mem_wdata,     v.exp_wdata);
    chk({v.name, "/gnts"},  64'({if_gnt, d_gnt}), v.is_d ? 64'd1 : 64'd2);
    for (int k = 0; k < v.delay; k++) begin
      @(negedge clk);
      chk({v.name, "/held"}, 64'({mem_req, if_rvalid, d_rvalid, mem_addr}),
          64'({1'b1, 1'b0, 1'b0, v.addr}));
    end
    mem_ack = 1'b1; mem_rdata = v.mrdata;
    #1;
    chk({v.name, "/rvalid"}, 64'({if_rvalid, d_rvalid}), v.is_d ? 64'd1 : 64'd2);
    if (v.is_d) chk({v.name, "/d_rdata"}, d_rdata, v.exp_rdata);
    else        chk({v.name, "/if_rdata"}, 64'(if_rdata), v.exp_rdata);
    @(posedge clk); #1;
    mem_ack = 1'b0; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk({v.name, "/release"}, 64'({mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid}), 64'd0);
  endtask

  logic [1:0] exp_ord[10];

  initial begin
    bit ok;
    vecs[0] = '{"fetch_2000", 1'b0, 1'b0, 32'h0000_2000, 64'h0,
                64'h1111_2222_3333_4444, 2, 1'b0, 1'b0, 64'h0, 64'h3333_4444};
    vecs[1] = '{"store_1000", 1'b1, 1'b1, 32'h0000_1000, 64'hDEAD_BEEF_CAFE_F00D,
                64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
    vecs[2] = '{"load_1008", 1'b1, 1'b0, 32'h0000_1008, 64'h5555_5555_5555_5555,
                64'h0123_4567_89AB_CDEF, 0, 1'b0, 1'b1, 64'h5555_5555_5555_5555,
                64'h0123_4567_89AB_CDEF};
    vecs[3] = '{"fetch_unal", 1'b0, 1'b0, 32'h0000_3003, 64'h0,
                64'hAAAA_BBBB_CCCC_DDDD, 3, 1'b0, 1'b0, 64'h0, 64'hCCCC_DDDD};
    vecs[4] = '{"load_top", 1'b1, 1'b0, 32'hFFFF_FFF8, 64'h0,
                64'h8000_0000_0000_0001, 4, 1'b0, 1'b1, 64'h0, 64'h8000_0000_0000_0001};
    exp_ord = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    // Reset state, including a stale ack during reset.
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we,
                             mem_size, arb_err}), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    chk("reset_wdata", mem_wdata, 64'd0);
    chk("reset_rdata", d_rdata | 64'(if_rdata), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'({mem_req, if_gnt, d_gnt}), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Both requesters held high, zero-wait memory: D,D,D,D,IF repeating.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int i = 0; i < 10; i++) begin
      wait_req(ok);
      if (!ok) begin
        chk("starve_timeout", 64'd0, 64'd1);
        break;
      end
      chk($sformatf("starve_order[%0d]", i), 64'({if_gnt, d_gnt}), 64'(exp_ord[i]));
      mem_ack = 1'b1;
      #1;
      chk($sformatf("starve_rvalid[%0d]", i), 64'({if_rvalid, d_rvalid}), 64'(exp_ord[i]));
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (i == 9) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    if_req = 1'b0; d_req = 1'b0;

    // Reset in BUSY_D before ack drops everything asynchronously.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    wait_req(ok);
    chk("rst_mid/d_gnt", 64'({ok, d_gnt}), 64'd3);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid/async_drop", 64'({mem_req, d_gnt, d_rvalid, if_gnt}), 64'd0);
    d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 64'h1234;
    @(negedge clk);
    chk("rst_mid/stale_ack", 64'({d_rvalid, if_rvalid, d_rdata}), 64'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rst_mid/still_idle", 64'({mem_req, d_gnt, if_gnt}), 64'd0);
    run_vec(vecs[2]);

    // Ack coincides with a still-high d_req: one IDLE cycle, then re-grant.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    wait_req(ok);
    mem_ack = 1'b1; mem_rdata = 64'h0A0A;
    #1;
    chk("b2b/first_rvalid", 64'({ok, d_rvalid}), 64'd3);
    @(posedge clk); #1;
    mem_ack = 1'b0; d_addr = 32'h508;
    @(negedge clk);
    chk("b2b/idle_gap", 64'({mem_req, d_gnt}), 64'd0);
    @(negedge clk);
    chk("b2b/regrant", 64'({mem_req, d_gnt, mem_addr}), 64'({2'b11, 32'h508}));
    mem_ack = 1'b1; mem_rdata = 64'h0B0B;
    #1;
    chk("b2b/second_rdata", d_rdata, 64'h0B0B);
    @(posedge clk); #1;
    mem_ack = 1'b0; d_req = 1'b0;

    // Watchdog: fetch with no ack.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h600; mem_rdata = 64'hFEED_FACE_DEAD_C0DE;
    wait_req(ok);
    chk("wdog/granted", 64'({ok, if_gnt}), 64'd3);
`ifdef TINKER_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("wdog/quiet[%0d]", k), 64'({arb_err, if_rvalid, mem_req}), 64'd1);
    end
    @(negedge clk);
    chk("wdog/fire", 64'({arb_err, if_rvalid}), 64'd3);
    chk("wdog/rdata_zero", 64'(if_rdata), 64'd0);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("wdog/after", 64'({arb_err, mem_req, if_gnt, if_rvalid}), 64'd0);
`else
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("nowdog/wait[%0d]", k), 64'({arb_err, if_rvalid, mem_req}), 64'd1);
    end
    mem_ack = 1'b1;
    #1;
    chk("nowdog/late_ack", 64'({arb_err, if_rvalid, if_rdata}), 64'({2'b01, 32'hDEAD_C0DE}));
    @(posedge clk); #1;
    mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("nowdog/after", 64'({mem_req, if_gnt}), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
